dds_ramp_sweep: RTL and testbench



---
 rtl/dds_ramp_sweep.sv | 174 +++++++++++++++++
 tb/tb_dds_ramp_sweep.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_ramp_sweep.sv
// Ramp generator for DDS tuning words: steps a registered word from start to end
// in fixed increments, holding each value for a programmable dwell.
module dds_ramp_sweep #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 32
) (
    input  logic                   dac_clk,
    input  logic                   rstn,
    input  logic                   cfg_load,
    input  logic [WIDTH-1:0]       cfg_start,
    input  logic [WIDTH-1:0]       cfg_end,
    input  logic [WIDTH-1:0]       cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [1:0]             cfg_mode,
    input  logic                   run,
    input  logic                   hold,
    output logic [WIDTH-1:0]       value_out,
    output logic                   value_valid,
    output logic                   sweep_done,
    output logic                   busy,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_sh_start;
    logic [WIDTH-1:0]       r_sh_end;
    logic [WIDTH-1:0]       r_sh_step;
    logic [WIDTH-1:0]       r_value;
    logic [DWELL_WIDTH-1:0] r_sh_dwell;
    logic [DWELL_WIDTH-1:0] r_cnt;
    logic [1:0]             r_sh_mode;
    logic                   r_dir_up;
    logic                   r_wrap_pending;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_out_up;
    logic                   w_return;
    logic                   w_dwell_done;
    logic                   w_at_end_out;
    logic                   w_at_start_ret;
    logic [WIDTH-1:0]       w_target;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_next;
    logic [WIDTH:0]         w_sum;
    logic [DWELL_WIDTH-1:0] w_dwell_max;

    // The outbound direction is fixed by the shadows; a mismatch with r_dir_up
    // means we are on the triangle return leg heading back to start.
    assign w_out_up     = (r_sh_end >= r_sh_start);
    assign w_return     = (r_dir_up != w_out_up);
    assign w_target     = w_return ? r_sh_start : r_sh_end;
    assign w_sum        = {1'b0, r_value} + {1'b0, r_sh_step};
    assign w_diff       = r_value - r_sh_step;
    assign w_dwell_max  = (r_sh_dwell == '0) ? {{(DWELL_WIDTH-1){1'b0}}, 1'b1} : r_sh_dwell;
    assign w_dwell_done = (r_cnt >= w_dwell_max);

    always_comb begin
        w_next = w_target;
        if (r_dir_up) begin
            if (w_sum < {1'b0, w_target}) w_next = w_sum[WIDTH-1:0];
        end else begin
            if (!(r_value < r_sh_step) && (w_diff > w_target)) w_next = w_diff;
        end
    end

    assign w_at_end_out   = !w_return && (w_next == r_sh_end);
    assign w_at_start_ret = w_return && (w_next == r_sh_start);

    // value_valid and sweep_done are single-cycle strobes with no back-pressure:
    // a consumer must take value_out on the cycle value_valid is high.
    always_ff @(posedge dac_clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_sh_start     <= '0;
            r_sh_end       <= '0;
            r_sh_step      <= '0;
            r_sh_dwell     <= '0;
            r_sh_mode      <= 2'd0;
            r_dir_up       <= 1'b1;
            r_wrap_pending <= 1'b0;
            r_cnt          <= '0;
            r_value        <= '0;
            r_valid        <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (cfg_load) begin
                r_sh_start     <= cfg_start;
                r_sh_end       <= cfg_end;
                r_sh_step      <= cfg_step;
                r_sh_dwell     <= cfg_dwell;
                r_sh_mode      <= cfg_mode;
                r_dir_up       <= (cfg_end >= cfg_start);
                r_wrap_pending <= 1'b0;
                r_cnt          <= '0;
                r_value        <= cfg_start;
                r_busy         <= 1'b0;
                r_state        <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run) begin
                            r_state <= S_DWELL;
                            r_cnt   <= {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (!run) begin
                            r_state        <= S_IDLE;
                            r_value        <= r_sh_start;
                            r_dir_up       <= w_out_up;
                            r_wrap_pending <= 1'b0;
                            r_busy         <= 1'b0;
                        end else if (!hold) begin
                            if (!w_dwell_done) begin
                                r_cnt <= r_cnt + 1'b1;
                            end else begin
                                r_cnt   <= {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
                                r_valid <= 1'b1;
                                if (r_wrap_pending) begin
                                    // sawtooth: end has been held one dwell, now wrap
                                    r_value        <= r_sh_start;
                                    r_done         <= 1'b1;
                                    r_wrap_pending <= 1'b0;
                                end else begin
                                    r_value <= w_next;
                                    if (w_at_end_out) begin
                                        case (r_sh_mode)
                                            2'd1: r_wrap_pending <= 1'b1;
                                            2'd2: r_dir_up       <= ~r_dir_up;
                                            default: begin
                                                r_state <= S_DONE;
                                                r_busy  <= 1'b0;
                                                r_done  <= 1'b1;
                                            end
                                        endcase
                                    end else if (w_at_start_ret) begin
                                        r_done   <= 1'b1;
                                        r_dir_up <= ~r_dir_up;
                                    end
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        if (!run) begin
                            r_state <= S_IDLE;
                            r_value <= r_sh_start;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign value_out   = r_value;
    assign value_valid = r_valid;
    assign sweep_done  = r_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dds_ramp_sweep.sv
// Bench for dds_ramp_sweep: directed vector table, hand-written corner sequences,
// and randomized traffic against a closed-form sweep model.
module tb_dds_ramp_sweep;
    localparam int W  = 32;
    localparam int DW = 32;

    logic          dac_clk = 1'b0;
    logic          rstn;
    logic          cfg_load;
    logic [W-1:0]  cfg_start;
    logic [W-1:0]  cfg_end;
    logic [W-1:0]  cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic          run;
    logic          hold;
    logic [W-1:0]  value_out;
    logic          value_valid;
    logic          sweep_done;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    dds_ramp_sweep #(.WIDTH(W), .DWELL_WIDTH(DW)) dut (
        .dac_clk     (dac_clk),
        .rstn        (rstn),
        .cfg_load    (cfg_load),
        .cfg_start   (cfg_start),
        .cfg_end     (cfg_end),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .run         (run),
        .hold        (hold),
        .value_out   (value_out),
        .value_valid (value_valid),
        .sweep_done  (sweep_done),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 dac_clk = ~dac_clk;

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [W-1:0]  st;
        logic [W-1:0]  en;
        logic [W-1:0]  sp;
        logic [DW-1:0] dw;
        logic [1:0]    mode;
        int            n;
        logic [W-1:0]  vals [6];
        logic [5:0]    dones;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [W-1:0] st, input logic [W-1:0] en, input logic [W-1:0] sp,
                           input logic [DW-1:0] dw, input logic [1:0] mode, input int n,
                           input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2,
                           input logic [W-1:0] v3, input logic [W-1:0] v4, input logic [W-1:0] v5,
                           input logic [5:0] dn);
        vec_t v;
        v.st = st; v.en = en; v.sp = sp; v.dw = dw; v.mode = mode; v.n = n;
        v.vals[0] = v0; v.vals[1] = v1; v.vals[2] = v2;
        v.vals[3] = v3; v.vals[4] = v4; v.vals[5] = v5;
        v.dones = dn;
        vecs.push_back(v);
    endtask

    task automatic load_cfg(input logic [W-1:0] st, input logic [W-1:0] en, input logic [W-1:0] sp,
                            input logic [DW-1:0] dw, input logic [1:0] mode);
        @(negedge dac_clk);
        cfg_start = st; cfg_end = en; cfg_step = sp; cfg_dwell = dw; cfg_mode = mode;
        cfg_load = 1'b1; run = 1'b0; hold = 1'b0;
        @(negedge dac_clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        do begin
            @(posedge dac_clk);
            edges++;
            @(negedge dac_clk);
        end while (!value_valid && edges < budget);
    endtask

    task automatic run_vec(input int id);
        vec_t v;
        int deff, e, last, got;
        v = vecs[id];
        deff = (v.dw == 0) ? 1 : int'(v.dw);
        load_cfg(v.st, v.en, v.sp, v.dw, v.mode);
        check($sformatf("v%0d_load_value", id), value_out, v.st);
        check($sformatf("v%0d_load_novalid", id), value_valid, 1'b0);
        run = 1'b1;
        @(posedge dac_clk);
        e = 0; last = 0; got = 0;
        while (got < v.n && e < 400) begin
            @(posedge dac_clk);
            e++;
            @(negedge dac_clk);
            if (value_valid) begin
                check($sformatf("v%0d_s%0d_value", id, got), value_out, v.vals[got]);
                check($sformatf("v%0d_s%0d_done", id, got), sweep_done, v.dones[got]);
                check($sformatf("v%0d_s%0d_spacing", id, got), e - last, deff);
                last = e;
                got++;
            end else if (sweep_done) begin
                check($sformatf("v%0d_stray_done", id), sweep_done, 1'b0);
            end
        end
        if (got < v.n) check($sformatf("v%0d_step_timeout", id), got, v.n);
        if ((v.mode == 2'd0 || v.mode == 2'd3) && v.dones[v.n-1]) begin
            check($sformatf("v%0d_busy_done", id), busy, 1'b0);
            check($sformatf("v%0d_state_done", id), dbg_state, 2'd2);
        end
        run = 1'b0;
        @(negedge dac_clk);
        check($sformatf("v%0d_abort_value", id), value_out, v.st);
        check($sformatf("v%0d_abort_busy", id), busy, 1'b0);
    endtask

    // ---------------- behavioural model ----------------
    longint       m_s, m_e, m_st, m_L;
    int           m_d, m_state, m_el, m_k;
    logic [1:0]   m_mode;
    logic [W-1:0] m_value;
    logic         m_valid, m_done, m_busy;

    // value reached after j steps from 'from' toward 'to', clamped at 'to'
    function automatic longint leg(input longint from, input longint to, input longint j);
        longint stepped;
        if (to >= from) begin
            stepped = from + j * m_st;
            return (stepped >= to) ? to : stepped;
        end
        stepped = from - j * m_st;
        return (stepped <= to) ? to : stepped;
    endfunction

    task automatic model_load();
        longint diff;
        m_s  = {32'd0, cfg_start};
        m_e  = {32'd0, cfg_end};
        m_st = {32'd0, cfg_step};
        diff = (m_e >= m_s) ? m_e - m_s : m_s - m_e;
        if (diff == 0)      m_L = 1;
        else if (m_st == 0) m_L = -1;
        else                m_L = (diff + m_st - 1) / m_st;
        m_d     = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_mode  = cfg_mode;
        m_value = cfg_start;
        m_state = 0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step_value(input int k, output logic [W-1:0] v, output logic d);
        longint j, p;
        d = 1'b0;
        if (m_L < 0) begin
            v = W'(leg(m_s, m_e, k));
        end else if (m_mode == 2'd1) begin
            p = m_L + 1;
            j = (k - 1) % p + 1;
            if (j == p) begin v = W'(m_s); d = 1'b1; end
            else v = W'(leg(m_s, m_e, j));
        end else if (m_mode == 2'd2) begin
            p = 2 * m_L;
            j = (k - 1) % p + 1;
            if (j <= m_L) v = W'(leg(m_s, m_e, j));
            else begin v = W'(leg(m_e, m_s, j - m_L)); d = (j == p); end
        end else begin
            v = W'(leg(m_s, m_e, k));
            d = (k == m_L);
        end
    endtask

    task automatic model_tick(input logic ld, input logic r, input logic h);
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (ld) begin
            model_load();
        end else if (m_state == 0) begin
            if (r) begin m_state = 1; m_el = 0; m_k = 0; m_busy = 1'b1; end
        end else if (m_state == 1) begin
            if (!r) begin
                m_state = 0; m_value = W'(m_s); m_busy = 1'b0;
            end else if (!h) begin
                m_el++;
                if (m_el == m_d) begin
                    m_el = 0;
                    m_k++;
                    model_step_value(m_k, m_value, m_done);
                    m_valid = 1'b1;
                    if ((m_mode == 2'd0 || m_mode == 2'd3) && m_k == m_L) begin
                        m_state = 2; m_busy = 1'b0;
                    end
                end
            end
        end else begin
            if (!r) begin m_state = 0; m_value = W'(m_s); end
        end
    endtask

    task automatic rand_cfg();
        logic [W-1:0] a, b, t;
        case ($urandom_range(0, 2))
            0: begin a = $urandom_range(0, 200); b = $urandom_range(0, 200); cfg_step = $urandom_range(0, 60); end
            1: begin
                a = 32'hFFFF_FF00 + $urandom_range(0, 255);
                b = 32'hFFFF_FF00 + $urandom_range(0, 255);
                cfg_step = $urandom_range(0, 128);
            end
            default: begin
                a = $urandom_range(0, 50);
                b = 32'hFFFF_FFFF - $urandom_range(0, 50);
                cfg_step = 32'h4000_0000 + $urandom_range(0, 1000);
            end
        endcase
        if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
        if ($urandom_range(0, 9) == 0) b = a;
        cfg_start = a;
        cfg_end   = b;
        cfg_dwell = $urandom_range(0, 4);
        cfg_mode  = $urandom_range(0, 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e, e2;
        logic ld, r, h;
        rstn = 1'b0; cfg_load = 1'b0; run = 1'b0; hold = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = 2'd0;
        repeat (2) @(negedge dac_clk);
        check("rst_value", value_out, 0);
        check("rst_valid", value_valid, 1'b0);
        check("rst_done", sweep_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rstn = 1'b1;

        add_vec(100, 130, 10, 3, 0, 3, 110, 120, 130, 0, 0, 0, 6'b000100);
        add_vec(50, 5, 20, 1, 0, 3, 30, 10, 5, 0, 0, 0, 6'b000100);
        add_vec(32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'h10, 0, 1, 5,
                32'hFFFF_FFD0, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'hFFFF_FFC0, 32'hFFFF_FFD0, 0, 6'b001000);
        add_vec(0, 4, 2, 2, 2, 6, 2, 4, 2, 0, 2, 4, 6'b001000);
        add_vec(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 6'b000001);
        add_vec(7, 7, 3, 1, 1, 4, 7, 7, 7, 7, 0, 0, 6'b001010);
        add_vec(10, 20, 0, 2, 2, 3, 10, 10, 10, 0, 0, 0, 6'b000000);
        add_vec(9, 9, 5, 2, 3, 1, 9, 0, 0, 0, 0, 0, 6'b000001);
        add_vec(10, 0, 4, 1, 2, 6, 6, 2, 0, 4, 8, 10, 6'b100000);
        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // hold for 5 cycles mid-dwell delays the next step by exactly 5
        load_cfg(100, 200, 10, 4, 0);
        run = 1'b1;
        @(posedge dac_clk);
        wait_valid(20, e);
        check("hold_first_edge", e, 4);
        check("hold_first_value", value_out, 110);
        @(posedge dac_clk);
        @(negedge dac_clk);
        hold = 1'b1;
        repeat (5) @(posedge dac_clk);
        @(negedge dac_clk);
        hold = 1'b0;
        wait_valid(20, e2);
        check("hold_delay", 6 + e2, 9);
        check("hold_second_value", value_out, 120);

        // run drop mid-sweep
        run = 1'b0;
        @(negedge dac_clk);
        check("drop_value", value_out, 100);
        check("drop_busy", busy, 1'b0);
        check("drop_valid", value_valid, 1'b0);

        // cfg_load mid-sweep
        run = 1'b1;
        @(posedge dac_clk);
        wait_valid(20, e);
        check("reload_pre_value", value_out, 110);
        cfg_start = 777; cfg_end = 900; cfg_step = 1; cfg_dwell = 2; cfg_mode = 2'd0;
        cfg_load = 1'b1;
        @(negedge dac_clk);
        cfg_load = 1'b0;
        check("reload_value", value_out, 777);
        check("reload_busy", busy, 1'b0);
        check("reload_state", dbg_state, 2'd0);
        check("reload_valid", value_valid, 1'b0);
        @(negedge dac_clk);
        check("reload_restart_busy", busy, 1'b1);
        wait_valid(20, e);
        check("reload_step_value", value_out, 778);

        // reset mid-sweep, then sweep with cleared shadows
        rstn = 1'b0;
        @(negedge dac_clk);
        check("midrst_value", value_out, 0);
        check("midrst_pulses", {value_valid, sweep_done}, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        rstn = 1'b1;
        @(negedge dac_clk);
        check("postrst_busy", busy, 1'b1);
        @(negedge dac_clk);
        check("postrst_value", value_out, 0);
        check("postrst_pulses", {value_valid, sweep_done}, 2'b11);
        check("postrst_busy_done", busy, 1'b0);
        check("postrst_state", dbg_state, 2'd2);
        run = 1'b0;

        // randomized traffic against the model
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge dac_clk);
            if (cyc > 0)
                check("rand_outputs", {value_out, value_valid, sweep_done, busy},
                      {m_value, m_valid, m_done, m_busy});
            ld = (cyc == 0) || (cyc % 150 == 0) || ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 95);
            h  = ($urandom_range(0, 99) < 15);
            if (ld) rand_cfg();
            cfg_load = ld;
            run      = r;
            hold     = h;
            model_tick(ld, r, h);
        end
        @(negedge dac_clk);
        check("rand_outputs_last", {value_out, value_valid, sweep_done, busy},
              {m_value, m_valid, m_done, m_busy});
        cfg_load = 1'b0;
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
